// File: rtl/multicycle_ctrl_if.sv
// Control-word / enable bundle between the multi-cycle sequencer and the
// surrounding datapath (ROM decode, PC, IR, REGBank, DMEM).
interface multicycle_ctrl_if #(
    parameter int WIDTH_DATA_LENGTH = 32
);
    // control word and handshake toward the sequencer
    logic                         regWEn;
    logic                         memRW;
    logic [1:0]                   wbSel;
    logic                         halt;
    logic                         memReady;
    // gated enables and status from the sequencer
    logic                         irLoad;
    logic                         pcWEn;
    logic                         regWEnOut;
    logic                         memReq;
    logic                         memWEn;
    logic                         err;
    logic [2:0]                   state;
    logic [WIDTH_DATA_LENGTH-1:0] cycleCount;
    logic [WIDTH_DATA_LENGTH-1:0] instRet;

    // datapath side: supplies the control word, consumes the enables
    modport master (
        output regWEn, memRW, wbSel, halt, memReady,
        input  irLoad, pcWEn, regWEnOut, memReq, memWEn, err, state,
               cycleCount, instRet
    );

    // sequencer side
    modport slave (
        input  regWEn, memRW, wbSel, halt, memReady,
        output irLoad, pcWEn, regWEnOut, memReq, memWEn, err, state,
               cycleCount, instRet
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// variable-latency DMEM handshake and timeout trap. Gates every architectural
// write enable so each instruction commits exactly once.
module multicycle_ctrl #(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int MEM_TIMEOUT       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_if.slave      bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

    state_t                       state_q, state_d;
    logic [7:0]                   wait_q, wait_d;
    logic [8:0]                   wait_inc;
    logic [WIDTH_DATA_LENGTH-1:0] cycle_q, ret_q;

    logic is_store, is_load;
    logic ir_load_c, pc_wen_c, reg_wen_c, mem_req_c, mem_wen_c, err_c;

    // The IR holds the control word stable from DECODE on, so decode is
    // purely combinational.
    assign is_store = bus.memRW;
    assign is_load  = !bus.memRW && bus.regWEn && (bus.wbSel == 2'b00);
    assign wait_inc = {1'b0, wait_q} + 9'd1;

    // State, wait counter and the two free-running counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cycle_q <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cycle_q <= cycle_q + 1'b1;
            ret_q   <= ret_q + WIDTH_DATA_LENGTH'(pc_wen_c);
        end
    end

    // Next-state and enable decode; reset forces every enable low so an
    // aborted instruction never commits anything in the reset cycle.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ir_load_c = 1'b0;
        pc_wen_c  = 1'b0;
        reg_wen_c = 1'b0;
        mem_req_c = 1'b0;
        mem_wen_c = 1'b0;
        err_c     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!bus.halt) begin
                    ir_load_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_wen_c = is_store;
                if (bus.memReady) begin
                    // a ready on the would-be timeout cycle still completes
                    if (is_store) begin
                        pc_wen_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end else begin
                    wait_d = wait_inc[7:0];
                    if (wait_inc == TIMEOUT)
                        state_d = S_ERROR;
                end
            end
            S_WB: begin
                reg_wen_c = bus.regWEn;
                pc_wen_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ERROR: err_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            ir_load_c = 1'b0;
            pc_wen_c  = 1'b0;
            reg_wen_c = 1'b0;
            mem_req_c = 1'b0;
            mem_wen_c = 1'b0;
        end
    end

    assign bus.irLoad     = ir_load_c;
    assign bus.pcWEn      = pc_wen_c;
    assign bus.regWEnOut  = reg_wen_c;
    assign bus.memReq     = mem_req_c;
    assign bus.memWEn     = mem_wen_c;
    assign bus.err        = err_c;
    assign bus.state      = state_q;
    assign bus.cycleCount = cycle_q;
    assign bus.instRet    = ret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver plans each instruction's
// timeline from the class/latency rules and queues its expected retirement;
// a negedge monitor checks per-cycle enables and pops on every pcWEn.
module tb_multicycle_ctrl;
    localparam int W      = 4;
    localparam int MEM_TO = 16;
    localparam int MASK   = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.WIDTH_DATA_LENGTH(W)) bus();

    multicycle_ctrl #(.WIDTH_DATA_LENGTH(W), .MEM_TIMEOUT(MEM_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        bit regw;
        bit memw;
        int ret;
    } sb_t;

    sb_t sb[$];
    int  vectors = 0;
    int  errors  = 0;
    int  mcyc    = 0;   // cycles since reset, per the counter rule
    int  mret    = 0;   // retired instructions (unmasked)
    int  exp_st  = 0;
    bit  chk_on  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rst) mcyc <= 0;
        else     mcyc <= mcyc + 1;
    end

    // monitor: per-cycle Moore outputs plus retirement scoreboard
    always @(negedge clk) begin
        if (chk_on) begin
            sb_t e;
            chk("state", bus.state, exp_st);
            chk("irLoad", bus.irLoad, (exp_st == 0) && !bus.halt && !rst);
            chk("memReq", bus.memReq, (exp_st == 3) && !rst);
            chk("memWEn", bus.memWEn, (exp_st == 3) && bus.memRW && !rst);
            chk("regWEnOut", bus.regWEnOut, (exp_st == 4) && bus.regWEn && !rst);
            if (!rst) chk("err", bus.err, exp_st == 7);
            chk("cycleCount", bus.cycleCount, mcyc & MASK);
            if (bus.pcWEn) begin
                if (sb.size() == 0) begin
                    chk("pcWEn_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("retire_cycle", mcyc, e.cyc);
                    chk("retire_regw", bus.regWEnOut, e.regw);
                    chk("retire_memw", bus.memWEn, e.memw);
                    chk("retire_instRet", bus.instRet, (e.ret - 1) & MASK);
                end
            end
        end
    end

    task automatic do_reset();
        chk("sb_empty_pre_rst", sb.size(), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        mret   = 0;
        exp_st = 0;
    endtask

    // cls: 0 ALU write, 1 load, 2 store, 3 non-writing other.
    // n: not-ready MEM cycles before memReady; rst_at: cycle index to reset in.
    task automatic run_inst(input int cls, input int h, input int n, input int rst_at);
        bit  ld, st, to;
        int  ret_k, last_k;
        sb_t e;
        for (int i = 0; i < h; i++) begin
            bus.halt     = 1'b1;
            bus.regWEn   = 1'($urandom_range(0, 1));
            bus.memRW    = 1'($urandom_range(0, 1));
            bus.wbSel    = 2'($urandom_range(0, 3));
            bus.memReady = 1'($urandom_range(0, 1));
            exp_st = 0;
            step();
        end
        bus.halt = 1'b0;
        case (cls)
            0:       begin bus.regWEn = 1'b1; bus.memRW = 1'b0; bus.wbSel = 2'b01; end
            1:       begin bus.regWEn = 1'b1; bus.memRW = 1'b0; bus.wbSel = 2'b00; end
            2:       begin bus.regWEn = 1'($urandom_range(0, 1)); bus.memRW = 1'b1;
                           bus.wbSel = 2'($urandom_range(0, 3)); end
            default: begin bus.regWEn = 1'b0; bus.memRW = 1'b0;
                           bus.wbSel = 2'($urandom_range(0, 3)); end
        endcase
        ld     = (cls == 1);
        st     = (cls == 2);
        to     = (ld || st) && (n >= MEM_TO);
        ret_k  = st ? 3 + n : (ld ? 4 + n : 3);
        last_k = to ? 3 + MEM_TO - 1 : ret_k;
        if (!to) begin
            mret++;
            e.cyc  = mcyc + ret_k;
            e.regw = (cls == 0) || ld;
            e.memw = st;
            e.ret  = mret;
            sb.push_back(e);
        end
        for (int k = 0; k <= last_k; k++) begin
            if (k > 0) bus.halt = 1'($urandom_range(0, 1));
            if (k < 3)                exp_st = k;
            else if (!(ld || st))     exp_st = 4;
            else if (ld && k == ret_k) exp_st = 4;
            else                      exp_st = 3;
            if (exp_st == 3) bus.memReady = (k - 3 >= n);
            else             bus.memReady = 1'($urandom_range(0, 1));
            if (k == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                sb.delete();
                mret   = 0;
                exp_st = 0;
                return;
            end
            step();
        end
        if (to) begin
            for (int i = 0; i < 4; i++) begin
                exp_st       = 7;
                bus.halt     = 1'($urandom_range(0, 1));
                bus.memReady = 1'($urandom_range(0, 1));
                step();
            end
            do_reset();
        end
    endtask

    initial begin
        int cls, h, n;
        bus.regWEn   = 1'b0;
        bus.memRW    = 1'b0;
        bus.wbSel    = 2'b00;
        bus.halt     = 1'b0;
        bus.memReady = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst    = 1'b0;
        exp_st = 0;
        chk_on = 1'b1;

        // ALU op straight out of reset: 4 cycles, one commit
        run_inst(0, 0, 0, -1);
        chk("alu_cycleCount", bus.cycleCount, 4);
        chk("alu_instRet", bus.instRet, 1);
        // load with three stall cycles, immediate store
        run_inst(1, 0, 3, -1);
        run_inst(2, 0, 0, -1);
        // store stuck not-ready: timeout trap, then reset recovery
        run_inst(2, 0, MEM_TO, -1);
        chk("post_err_state", bus.state, 0);
        chk("post_err_err", bus.err, 0);
        // ready arriving on the last tolerated cycle completes normally
        run_inst(2, 0, MEM_TO - 1, -1);
        run_inst(1, 0, MEM_TO - 1, -1);
        // five halt cycles in FETCH
        run_inst(0, 5, 0, -1);
        // reset in the third MEM cycle of a stalled store
        run_inst(2, 0, 5, 5);
        chk("rst_instRet", bus.instRet, 0);
        chk("rst_cycleCount", bus.cycleCount, 0);
        // 16 ALU ops wrap a 4-bit retire counter
        for (int i = 0; i < 16; i++) run_inst(0, 0, 0, -1);
        chk("instRet_wrap", bus.instRet, 0);
        // randomized mix
        for (int i = 0; i < 150; i++) begin
            cls = $urandom_range(0, 3);
            h   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            n   = ($urandom_range(0, 19) == 0) ? MEM_TO : $urandom_range(0, 4);
            run_inst(cls, h, n, -1);
        end
        bus.halt = 1'b1;
        exp_st   = 0;
        step();
        step();
        chk("sb_drain", sb.size(), 0);
        chk("final_instRet", bus.instRet, mret & MASK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
